// File: rtl/alu_seq.sv
// Multi-cycle MIPS ALU: single-cycle logic/arith/shift ops plus an iterative
// shift-add MULTU, with start/busy/done handshake and held registered results.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic {IDLE, MUL} state_t;

  typedef enum logic [2:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_ADD   = 3'b010,
    OP_MULTU = 3'b011,
    OP_SLL   = 3'b100,
    OP_SRL   = 3'b101,
    OP_SUB   = 3'b110,
    OP_SLT   = 3'b111
  } op_t;

  state_t             state, state_n;
  op_t                op;
  logic [WIDTH-1:0]   mcand, mcand_n;
  logic [2*WIDTH-1:0] prod, prod_n, prod_step;
  logic [SHW:0]       cnt, cnt_n;
  logic               busy_n, done_n, zero_n, carry_n, ovf_n;
  logic [WIDTH-1:0]   lo_n, hi_n;

  logic [WIDTH-1:0]   bx;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     step_sum;
  logic               ovf_as, slt;

  assign op = op_t'(aluop);

  // aluop[2] selects ~b with carry-in 1, so SUB and SLT share the adder.
  always_comb begin
    bx     = aluop[2] ? ~b : b;
    sum    = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, aluop[2]};
    ovf_as = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    slt    = sum[WIDTH-1] ^ ovf_as;
  end

  // Upper half of prod is the accumulator, lower half the shifting multiplier.
  always_comb begin
    step_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_step = {step_sum, prod[WIDTH-1:1]};
  end

  always_comb begin
    state_n = state;
    mcand_n = mcand;
    prod_n  = prod;
    cnt_n   = cnt;
    busy_n  = busy;
    done_n  = 1'b0;
    lo_n    = result_lo;
    hi_n    = result_hi;
    zero_n  = zero;
    carry_n = carry;
    ovf_n   = overflow;

    unique case (state)
      IDLE: begin
        if (start) begin
          if (op == OP_MULTU) begin
            mcand_n = a;
            prod_n  = {{WIDTH{1'b0}}, b};
            cnt_n   = (SHW+1)'(WIDTH);
            busy_n  = 1'b1;
            state_n = MUL;
          end else begin
            done_n  = 1'b1;
            hi_n    = '0;
            carry_n = 1'b0;
            ovf_n   = 1'b0;
            case (op)
              OP_AND: lo_n = a & b;
              OP_OR:  lo_n = a | b;
              OP_ADD, OP_SUB: begin
                lo_n    = sum[WIDTH-1:0];
                carry_n = sum[WIDTH];
                ovf_n   = ovf_as;
              end
              OP_SLT: begin
                lo_n    = {{(WIDTH-1){1'b0}}, slt};
                carry_n = sum[WIDTH];
              end
              OP_SLL: lo_n = a << b[SHW-1:0];
              OP_SRL: lo_n = a >> b[SHW-1:0];
              default: lo_n = '0;
            endcase
            zero_n = (lo_n == '0);
          end
        end
      end
      MUL: begin
        prod_n = prod_step;
        cnt_n  = cnt - 1'b1;
        if (cnt == 1) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          lo_n    = prod_step[WIDTH-1:0];
          hi_n    = prod_step[2*WIDTH-1:WIDTH];
          zero_n  = (prod_step[WIDTH-1:0] == '0);
          carry_n = 1'b0;
          ovf_n   = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mcand     <= '0;
      prod      <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      mcand     <= mcand_n;
      prod      <= prod_n;
      cnt       <= cnt_n;
      busy      <= busy_n;
      done      <= done_n;
      result_lo <= lo_n;
      result_hi <= hi_n;
      zero      <= zero_n;
      carry     <= carry_n;
      overflow  <= ovf_n;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=32): behavioural reference model checked every cycle,
// directed corner cases with literal expectations, then randomized traffic.
module tb_alu_seq;

  localparam logic [2:0] AND_ = 3'b000, OR_ = 3'b001, ADD_ = 3'b010, MULTU_ = 3'b011,
                         SLL_ = 3'b100, SRL_ = 3'b101, SUB_ = 3'b110, SLT_ = 3'b111;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  aluop;
  logic [31:0] a, b;
  logic        busy, done, zero, carry, overflow;
  logic [31:0] result_lo, result_hi;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic        e_busy, e_done, e_zero, e_carry, e_ovf;
  logic [31:0] e_lo, e_hi, m_a, m_b;
  int          m_cnt;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .aluop(aluop), .a(a), .b(b),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
    .zero(zero), .carry(carry), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    e_busy = 0; e_done = 0; e_zero = 0; e_carry = 0; e_ovf = 0;
    e_lo = '0; e_hi = '0; m_a = '0; m_b = '0; m_cnt = 0;
  endtask

  task automatic model_single(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e_hi = '0; e_carry = 0; e_ovf = 0;
    case (op)
      AND_: e_lo = x & y;
      OR_:  e_lo = x | y;
      ADD_: begin
        r = sx + sy;
        e_lo = x + y;
        e_carry = ((64'(x) + 64'(y)) >> 32) != 0;
        e_ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      SUB_: begin
        r = sx - sy;
        e_lo = x - y;
        e_carry = (x >= y);
        e_ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      SLT_: begin
        e_lo = (sx < sy) ? 32'd1 : 32'd0;
        e_carry = (x >= y);
      end
      SLL_: e_lo = x << (y % 32);
      SRL_: e_lo = x >> (y % 32);
      default: e_lo = '0;
    endcase
    e_zero = (e_lo == 0);
  endtask

  // Advances the model by one rising edge using the inputs the DUT sampled.
  task automatic model_step();
    logic [63:0] p;
    if (rst) begin
      model_clear();
      return;
    end
    e_done = 0;
    if (e_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        p = 64'(m_a) * 64'(m_b);
        e_lo = p[31:0]; e_hi = p[63:32];
        e_zero = (e_lo == 0); e_carry = 0; e_ovf = 0;
        e_done = 1; e_busy = 0;
      end
    end else if (start) begin
      if (aluop == MULTU_) begin
        m_a = a; m_b = b; m_cnt = 32; e_busy = 1;
      end else begin
        model_single(aluop, a, b);
        e_done = 1;
      end
    end
  endtask

  task automatic tick(input logic s, input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    start = s; aluop = op; a = x; b = y;
    @(posedge clk);
    model_step();
    #1;
    start = 0; aluop = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    chk("done", done, e_done);
    chk("busy", busy, e_busy);
    chk("result_lo", result_lo, e_lo);
    chk("result_hi", result_hi, e_hi);
    chk("zero", zero, e_zero);
    chk("carry", carry, e_carry);
    chk("overflow", overflow, e_ovf);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    model_clear();
    rst = 1; start = 0; aluop = '0; a = '0; b = '0;
    tick(0, AND_, 0, 0);
    tick(0, AND_, 0, 0);
    chk("reset_busy", busy, 0);
    chk("reset_lo", result_lo, 0);
    chk("reset_hi", result_hi, 0);
    #1 rst = 0;

    // ADD signed overflow
    tick(1, ADD_, 32'h7FFFFFFF, 32'd1);
    chk("add_done", done, 1);
    chk("add_lo", result_lo, 32'h80000000);
    chk("add_ovf", overflow, 1);
    chk("add_carry", carry, 0);
    chk("add_zero", zero, 0);

    tick(1, SUB_, 32'd5, 32'd5);
    chk("sub_lo", result_lo, 0);
    chk("sub_zero", zero, 1);
    chk("sub_carry", carry, 1);
    tick(1, SLT_, 32'h80000000, 32'h7FFFFFFF);
    chk("slt_ovf_case", result_lo, 1);
    tick(1, SLT_, 32'd1, 32'hFFFFFFFF);
    chk("slt_neg_b", result_lo, 0);

    // MULTU max*max with an ignored ADD while busy
    tick(1, MULTU_, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("mul_busy", busy, 1);
    chk("mul_nodone", done, 0);
    cyc = 0;
    while (cyc < 40) begin
      tick(cyc == 4, ADD_, 32'd2, 32'd3);
      cyc++;
      if (done) break;
    end
    chk("mul_latency", 64'(cyc), 64'd32);
    chk("mul_hi", result_hi, 32'hFFFFFFFE);
    chk("mul_lo", result_lo, 32'h00000001);
    chk("mul_busy_end", busy, 0);

    // Reset mid-MULTU
    tick(1, MULTU_, 32'd7, 32'd9);
    repeat (9) tick(0, AND_, 0, 0);
    #2 rst = 1;
    model_clear();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_lo", result_lo, 0);
    chk("rst_zero", zero, 0);
    tick(0, AND_, 0, 0);
    #1 rst = 0;
    repeat (40) tick(0, AND_, 0, 0);
    tick(1, ADD_, 32'd2, 32'd3);
    chk("post_rst_add_done", done, 1);
    chk("post_rst_add_lo", result_lo, 32'd5);

    // Shifts: only b[4:0] counts
    tick(1, SLL_, 32'd1, 32'd31);
    chk("sll", result_lo, 32'h80000000);
    tick(1, SRL_, 32'h80000000, 32'd35);
    chk("srl", result_lo, 32'h10000000);

    // Back-to-back: start held in the done cycle
    tick(1, ADD_, 32'd10, 32'd20);
    chk("b2b_done1", done, 1);
    chk("b2b_lo1", result_lo, 32'd30);
    tick(1, OR_, 32'hF0F0_0000, 32'h0000_0F0F);
    chk("b2b_done2", done, 1);
    chk("b2b_lo2", result_lo, 32'hF0F0_0F0F);

    // Randomized traffic, including starts issued while busy
    for (int i = 0; i < 4000; i++) begin
      logic [2:0] op;
      op = 3'($urandom);
      tick($urandom_range(0, 2) == 0, op, rnd_val(), rnd_val());
    end
    repeat (40) tick(0, AND_, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
